// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage; runs a req/ready handshake to data memory
// for load/store/push/pop and owns the stack pointer.
module mem_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter logic [ADDR_W-1:0] SP_RESET = {ADDR_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_out,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [2:0]        ex_rdst,
    input  logic              ex_reg_write,
    input  logic              ex_mem_read,
    input  logic              ex_mem_write,
    input  logic              ex_push,
    input  logic              ex_pop,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ready,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [2:0]        wb_rdst,
    output logic              wb_reg_write,
    output logic [ADDR_W-1:0] sp
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_nx;
    logic       is_mem, accept, alu_done, done, rw_q, wr;
    logic [2:0] rdst_q;

    assign is_mem   = ex_push | ex_pop | ex_mem_write | ex_mem_read;
    assign accept   = (state == IDLE) & ex_valid & is_mem;
    assign alu_done = (state == IDLE) & ex_valid & ~is_mem;
    assign done     = (state == BUSY) & dmem_ready;
    assign stall    = ex_valid & is_mem & ~done;
    assign dmem_req = (state == BUSY);
    // push > pop > store > load: only push and store write
    assign wr       = ex_push | (~ex_pop & ex_mem_write);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        state_nx = accept ? BUSY : done ? IDLE : state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp           <= SP_RESET;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wdata   <= '0;
            rdst_q       <= '0;
            rw_q         <= 1'b0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rdst      <= '0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid <= alu_done | done;
            if (alu_done) begin
                wb_data      <= ex_alu_out;
                wb_rdst      <= ex_rdst;
                wb_reg_write <= ex_reg_write;
            end else if (done) begin
                // writes report their address, reads report the returned data
                wb_data      <= dmem_we ? DATA_W'(dmem_addr) : dmem_rdata;
                wb_rdst      <= rdst_q;
                wb_reg_write <= rw_q;
            end
            if (accept) begin
                rdst_q    <= ex_rdst;
                rw_q      <= ex_reg_write;
                dmem_we   <= wr;
                dmem_addr <= ex_push ? sp : ex_pop ? sp + 1'b1 : ADDR_W'(ex_alu_out);
                if (wr) dmem_wdata <= ex_store_data;
                if (ex_push)     sp <= sp - 1'b1;
                else if (ex_pop) sp <= sp + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a
// behavioural instruction-level model (stack pointer + memory image).
module tb_mem_stage;
    logic        clk = 1'b0, rst = 1'b1;
    logic        ex_valid = 0, ex_reg_write = 0, ex_mem_read = 0, ex_mem_write = 0, ex_push = 0, ex_pop = 0;
    logic [15:0] ex_alu_out = 0, ex_store_data = 0, dmem_rdata = 0;
    logic [2:0]  ex_rdst = 0;
    logic        dmem_ready = 0;
    logic        stall, dmem_req, dmem_we, wb_valid, wb_reg_write;
    logic [15:0] dmem_addr, dmem_wdata, wb_data, sp;
    logic [2:0]  wb_rdst;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_out(ex_alu_out),
        .ex_store_data(ex_store_data), .ex_rdst(ex_rdst), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_push(ex_push),
        .ex_pop(ex_pop), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_rdst(wb_rdst), .wb_reg_write(wb_reg_write), .sp(sp)
    );

    typedef enum int {OP_ALU, OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_e;
    typedef struct packed {
        logic        ok;
        logic        stable;
        int          req_cycles;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic        valid;
        logic [15:0] data;
        logic [2:0]  rdst;
        logic        rw;
        logic [15:0] sp;
    } obs_t;

    int          checks = 0, errors = 0;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] seen [$];
    logic [15:0] sp_ref;

    // every retired instruction's result, sampled mid-cycle
    always @(posedge clk) begin
        #3;
        if (wb_valid === 1'b1) seen.push_back(wb_data);
    end

    function automatic logic [15:0] bg(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction
    function automatic logic [15:0] rd_mem(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : bg(a);
    endfunction
    function automatic logic [15:0] rd_ref(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : bg(a);
    endfunction

    // instruction-level semantics: what each op must do to sp, memory and writeback
    task automatic model(input op_e op, input logic [15:0] alu, sd, output logic [15:0] addr, wdata, data, output logic we);
        addr = alu; wdata = sd; data = alu; we = 1'b0;
        case (op)
            OP_LOAD:  data = rd_ref(alu);
            OP_STORE: begin we = 1'b1; ref_mem[alu] = sd; end
            OP_PUSH:  begin addr = sp_ref; we = 1'b1; data = sp_ref; ref_mem[sp_ref] = sd; sp_ref = sp_ref - 16'd1; end
            OP_POP:   begin sp_ref = sp_ref + 16'd1; addr = sp_ref; data = rd_ref(sp_ref); end
            default: ;
        endcase
    endtask

    // drives one instruction and plays the memory; returns observations only
    task automatic run_op(input op_e op, input logic [15:0] alu, sd, input logic [2:0] rd, input logic rw,
                          input int waits, input logic extra, output obs_t o);
        logic is_mem;
        is_mem = (op != OP_ALU);
        o = '0; o.ok = 1'b1; o.stable = 1'b1;
        dmem_ready = 1'b0;
        ex_valid = 1'b1; ex_alu_out = alu; ex_store_data = sd; ex_rdst = rd; ex_reg_write = rw;
        ex_push      = (op == OP_PUSH);
        ex_pop       = (op == OP_POP) || (extra && op == OP_PUSH && $urandom_range(0, 1) == 1);
        ex_mem_write = (op == OP_STORE) || (extra && (op == OP_PUSH || op == OP_POP) && $urandom_range(0, 1) == 1);
        ex_mem_read  = (op == OP_LOAD) || (extra && is_mem && $urandom_range(0, 1) == 1);
        #1;
        if (stall !== is_mem || dmem_req !== 1'b0) o.ok = 1'b0;
        if (is_mem) begin
            @(negedge clk);
            o.addr = dmem_addr; o.we = dmem_we; o.wdata = dmem_wdata;
            for (int w = 0; w <= waits; w++) begin
                if (w > 0) @(negedge clk);
                if (dmem_req === 1'b1) o.req_cycles++;
                if ({dmem_addr, dmem_we, dmem_wdata} !== {o.addr, o.we, o.wdata}) o.stable = 1'b0;
                if (stall !== 1'b1 || wb_valid !== 1'b0) o.ok = 1'b0;
            end
            dmem_rdata = dmem_we ? 16'($urandom) : rd_mem(dmem_addr);
            if (dmem_we) mem[dmem_addr] = dmem_wdata;
            dmem_ready = 1'b1;
            #1;
            if (stall !== 1'b0) o.ok = 1'b0;
        end
        @(negedge clk);
        ex_valid = 0; ex_push = 0; ex_pop = 0; ex_mem_write = 0; ex_mem_read = 0;
        dmem_ready = 1'b0; dmem_rdata = 16'($urandom);
        o.valid = wb_valid; o.data = wb_data; o.rdst = wb_rdst; o.rw = wb_reg_write; o.sp = sp;
    endtask

    task automatic test_reset;
        logic [54:0] r;
        rst = 1'b1; ex_valid = 0; dmem_ready = 0;
        repeat (2) @(negedge clk);
        r = {dmem_req, dmem_we, wb_valid, wb_reg_write, wb_rdst, dmem_addr, dmem_wdata, wb_data};
        checks++; if (r !== '0) begin errors++; $display("FAIL reset_outputs: got %h want 0", r); end
        checks++; if (sp !== 16'hFFFF) begin errors++; $display("FAIL reset_sp: got %h want ffff", sp); end
        rst = 1'b0; sp_ref = 16'hFFFF; mem.delete(); ref_mem.delete();
        @(negedge clk);
        seen.delete();
    endtask

    task automatic test_alu;
        obs_t o;
        run_op(OP_ALU, 16'h1234, 16'h0, 3'd3, 1'b1, 0, 1'b0, o);
        checks++; if (o.ok !== 1'b1) begin errors++; $display("FAIL alu_stall: got %b want 1", o.ok); end
        checks++; if ({o.valid, o.data, o.rdst, o.rw} !== {1'b1, 16'h1234, 3'd3, 1'b1})
            begin errors++; $display("FAIL alu_wb: got %b %h %0d %b want 1 1234 3 1", o.valid, o.data, o.rdst, o.rw); end
    endtask

    task automatic test_idle;
        dmem_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if ({dmem_req, wb_valid, stall} !== 3'b000) begin errors++; $display("FAIL idle_ready_ignored: got %b want 000", {dmem_req, wb_valid, stall}); end
            checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL idle_hold: got %h want 1234", wb_data); end
        end
        dmem_ready = 1'b0;
    endtask

    task automatic test_load;
        obs_t o;
        mem[16'h0040] = 16'hBEEF; ref_mem[16'h0040] = 16'hBEEF;
        seen.delete();
        run_op(OP_LOAD, 16'h0040, 16'h0, 3'd5, 1'b1, 3, 1'b0, o);
        @(negedge clk);
        checks++; if (o.req_cycles != 4) begin errors++; $display("FAIL load_req_cycles: got %0d want 4", o.req_cycles); end
        checks++; if ({o.ok, o.stable} !== 2'b11) begin errors++; $display("FAIL load_stall_stable: got %b want 11", {o.ok, o.stable}); end
        checks++; if ({o.addr, o.we} !== {16'h0040, 1'b0}) begin errors++; $display("FAIL load_req: got %h %b want 0040 0", o.addr, o.we); end
        checks++; if ({o.valid, o.data, o.rdst} !== {1'b1, 16'hBEEF, 3'd5}) begin errors++; $display("FAIL load_wb: got %b %h %0d want 1 beef 5", o.valid, o.data, o.rdst); end
        checks++; if (seen.size() != 1) begin errors++; $display("FAIL load_retire_once: got %0d want 1", seen.size()); end
    endtask

    task automatic test_push_pop;
        obs_t o;
        test_reset();
        run_op(OP_PUSH, 16'h0, 16'hAAAA, 3'd0, 1'b0, 1, 1'b0, o);
        checks++; if ({o.addr, o.we, o.wdata, o.sp} !== {16'hFFFF, 1'b1, 16'hAAAA, 16'hFFFE})
            begin errors++; $display("FAIL push: got %h %b %h sp %h want ffff 1 aaaa sp fffe", o.addr, o.we, o.wdata, o.sp); end
        run_op(OP_POP, 16'h0, 16'h0, 3'd1, 1'b1, 0, 1'b0, o);
        checks++; if ({o.addr, o.we, o.sp} !== {16'hFFFF, 1'b0, 16'hFFFF})
            begin errors++; $display("FAIL pop_req: got %h %b sp %h want ffff 0 sp ffff", o.addr, o.we, o.sp); end
        checks++; if ({o.valid, o.data, o.rdst} !== {1'b1, 16'hAAAA, 3'd1})
            begin errors++; $display("FAIL pop_wb: got %b %h %0d want 1 aaaa 1", o.valid, o.data, o.rdst); end
    endtask

    task automatic test_wrap;
        obs_t o;
        test_reset();
        run_op(OP_POP, 16'h0, 16'h0, 3'd2, 1'b1, 0, 1'b0, o);
        checks++; if ({o.addr, o.sp} !== {16'h0000, 16'h0000}) begin errors++; $display("FAIL wrap_pop: got %h sp %h want 0000 sp 0000", o.addr, o.sp); end
        run_op(OP_PUSH, 16'h0, 16'h5555, 3'd0, 1'b0, 0, 1'b0, o);
        checks++; if ({o.addr, o.sp} !== {16'h0000, 16'hFFFF}) begin errors++; $display("FAIL wrap_push: got %h sp %h want 0000 sp ffff", o.addr, o.sp); end
    endtask

    task automatic test_back_to_back;
        obs_t o1, o2, o3;
        seen.delete();
        run_op(OP_STORE, 16'h0100, 16'h7777, 3'd0, 1'b0, 2, 1'b0, o1);
        run_op(OP_ALU, 16'h4321, 16'h0, 3'd4, 1'b1, 0, 1'b0, o2);
        run_op(OP_LOAD, 16'h0100, 16'h0, 3'd6, 1'b1, 1, 1'b0, o3);
        @(negedge clk);
        checks++; if (o2.valid !== 1'b1 || o2.data !== 16'h4321) begin errors++; $display("FAIL b2b_alu_latency: got %b %h want 1 4321", o2.valid, o2.data); end
        checks++; if (seen.size() != 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", seen.size()); end
        else begin
            checks++; if ({seen[0], seen[1], seen[2]} !== {16'h0100, 16'h4321, 16'h7777})
                begin errors++; $display("FAIL b2b_order: got %h %h %h want 0100 4321 7777", seen[0], seen[1], seen[2]); end
        end
    endtask

    task automatic test_reset_busy;
        obs_t o;
        test_reset();
        run_op(OP_PUSH, 16'h0, 16'h1111, 3'd0, 1'b0, 0, 1'b0, o);
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_alu_out = 16'h0200; ex_rdst = 3'd2;
        @(negedge clk);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b want 1", dmem_req); end
        #1 rst = 1'b1;
        #1;
        checks++; if ({dmem_req, wb_valid, sp} !== {1'b0, 1'b0, 16'hFFFF}) begin errors++; $display("FAIL rb_async: got %b %b sp %h want 0 0 sp ffff", dmem_req, wb_valid, sp); end
        ex_valid = 1'b0; ex_mem_read = 1'b0; dmem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; dmem_ready = 1'b0; sp_ref = 16'hFFFF;
        @(negedge clk);
        checks++; if ({dmem_req, wb_valid} !== 2'b00) begin errors++; $display("FAIL rb_after: got %b want 00", {dmem_req, wb_valid}); end
        run_op(OP_PUSH, 16'h0, 16'h2222, 3'd0, 1'b0, 0, 1'b0, o);
        checks++; if ({o.addr, o.sp, o.valid} !== {16'hFFFF, 16'hFFFE, 1'b1}) begin errors++; $display("FAIL rb_next: got %h sp %h %b want ffff sp fffe 1", o.addr, o.sp, o.valid); end
    endtask

    task automatic test_random;
        obs_t o;
        op_e op;
        logic [15:0] alu, sd, e_addr, e_wdata, e_data;
        logic [2:0] rd;
        logic rw, e_we;
        int n = 200;
        test_reset();
        seen.delete();
        for (int i = 0; i < n; i++) begin
            op  = op_e'($urandom_range(0, 4));
            alu = 16'hFFF0 | 16'($urandom_range(0, 15));
            sd  = 16'($urandom);
            rd  = 3'($urandom);
            rw  = 1'($urandom);
            model(op, alu, sd, e_addr, e_wdata, e_data, e_we);
            run_op(op, alu, sd, rd, rw, $urandom_range(0, 3), 1'b1, o);
            checks++; if ({o.ok, o.stable} !== 2'b11) begin errors++; $display("FAIL rnd_handshake op%0d: got %b want 11", op, {o.ok, o.stable}); end
            checks++; if ({o.valid, o.data, o.rdst, o.rw, o.sp} !== {1'b1, e_data, rd, rw, sp_ref})
                begin errors++; $display("FAIL rnd_wb op%0d: got %b %h %0d %b sp %h want 1 %h %0d %b sp %h", op, o.valid, o.data, o.rdst, o.rw, o.sp, e_data, rd, rw, sp_ref); end
            if (op != OP_ALU) begin
                checks++; if ({o.addr, o.we} !== {e_addr, e_we}) begin errors++; $display("FAIL rnd_req op%0d: got %h %b want %h %b", op, o.addr, o.we, e_addr, e_we); end
                if (e_we) begin
                    checks++; if (o.wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata: got %h want %h", o.wdata, e_wdata); end
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                dmem_ready = 1'($urandom);
                @(negedge clk);
                dmem_ready = 1'b0;
                checks++; if ({wb_valid, dmem_req, wb_data} !== {2'b00, e_data}) begin errors++; $display("FAIL rnd_gap: got %b %b %h want 0 0 %h", wb_valid, dmem_req, wb_data, e_data); end
            end
        end
        @(negedge clk);
        checks++; if (seen.size() != n) begin errors++; $display("FAIL rnd_retire_count: got %0d want %0d", seen.size(), n); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_idle();
        test_load();
        test_push_pop();
        test_wrap();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
